// File: rtl/freq_div_sched_if.sv
// -----------------------------------------------------------------------------
// freq_div_sched_if
//   Configuration channel for freq_div_sched. It carries one valid/ready
//   request that retargets a single divider channel.
//
//   cfg_valid  requester -> scheduler  request valid, held until accepted
//   cfg_ready  scheduler -> requester  request is accepted this cycle
//   cfg_ch     requester -> scheduler  target channel index
//   cfg_div    requester -> scheduler  divisor d (0 is treated as 1)
//   cfg_en     requester -> scheduler  1 = run channel at d, 0 = stop channel
// -----------------------------------------------------------------------------
interface freq_div_sched_if #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/freq_div_sched.sv
// -----------------------------------------------------------------------------
// freq_div_sched
//   Multi-channel programmable clock-enable scheduler. Each channel owns a
//   terminal-count counter that produces a one-cycle tick every d cycles and
//   a square wave of period 2*d. Changes to a running channel are held back
//   until that channel's period boundary, so downstream logic never sees a
//   shortened or stretched period.
//
//   clk      system clock, rising edge
//   rst      synchronous active-high reset, overrides everything
//   cfg      configuration request port (freq_div_sched_if.slave)
//   tick     per-channel one-cycle enable, once every d cycles
//   div_out  per-channel square wave, period 2*d cycles
//   busy     a configuration request is waiting for its boundary or committing
// -----------------------------------------------------------------------------
module freq_div_sched #(
  parameter int CNT_W = 16,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  freq_div_sched_if.slave   cfg,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    div_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    COMMIT
  } state_t;

  // One bit wider than cfg_ch so NCH == 2^CH_W still fits.
  localparam logic [CH_W:0] NCH_LIM = (CH_W + 1)'(NCH);

  state_t state, state_nxt;

  // Per-channel state
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   out_q;
  logic [CNT_W-1:0] div_q [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];

  // Latched request
  logic [CH_W-1:0]  lat_ch;
  logic [CNT_W-1:0] lat_div;
  logic             lat_en;

  logic             accept;
  logic             ch_ok;
  logic             target_en;
  logic             bnd_hit;
  logic [NCH-1:0]   sel;
  logic [NCH-1:0]   upd;

  assign cfg.cfg_ready = (state == IDLE) & ~rst;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign ch_ok         = {1'b0, cfg.cfg_ch} < NCH_LIM;
  assign busy          = (state != IDLE);
  assign div_out       = out_q;

  // Tick is decoded purely from registers. div_q is never 0, so div_q-1
  // cannot wrap and the compare stays within CNT_W bits.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tick[i] = en_q[i] & (cnt_q[i] == div_q[i] - CNT_W'(1));
    end
  end

  // NOTE: every variable driven here gets a default before any branch, so a
  // missing case arm can never leave a stale value behind as a latch.
  always_comb begin
    sel       = '0;
    target_en = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      sel[i] = (lat_ch == CH_W'(i));
      if (cfg.cfg_ch == CH_W'(i)) begin
        target_en = en_q[i];
      end
    end
  end

  assign bnd_hit = |(sel & tick);

  // Channel selected for an update this edge: unconditionally in COMMIT,
  // only on its own tick while waiting for the boundary.
  always_comb begin
    upd = '0;
    if (state == COMMIT) begin
      upd = sel;
    end else if (state == WAIT_BND) begin
      upd = sel & tick;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Out-of-range channels are accepted and silently dropped.
        if (accept && ch_ok) begin
          state_nxt = target_en ? WAIT_BND : COMMIT;
        end
      end
      WAIT_BND: if (bnd_hit) state_nxt = IDLE;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the latched request carries no reset; it is only consumed in
  // WAIT_BND/COMMIT, which are entered on the same edge that loads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_ch  <= cfg.cfg_ch;
      lat_div <= (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;
      lat_en  <= cfg.cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        en_q[i]  <= 1'b0;
        out_q[i] <= 1'b0;
        div_q[i] <= CNT_W'(1);
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (upd[i]) begin
          en_q[i]  <= lat_en;
          div_q[i] <= lat_div;
          cnt_q[i] <= '0;
          // A boundary commit on a running channel keeps the square wave in
          // phase by toggling as usual; a stop or a fresh start begins low.
          out_q[i] <= (state == WAIT_BND) ? (lat_en & ~out_q[i]) : 1'b0;
        end else if (en_q[i]) begin
          if (tick[i]) begin
            cnt_q[i] <= '0;
            out_q[i] <= ~out_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
          out_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule
